// File: rtl/triumph_pkg.sv
// Shared constants and types for the triumph decode stage.
// Instruction format: [31:26] op, [25:21] rd, [20:16] rs1, [15:11] rs2, [15:0] imm16.
package triumph_pkg;
  localparam int XLEN    = 32;
  localparam int NREGS   = 32;
  localparam int REG_AW  = 5;
  localparam int OP_LSB  = 26;
  localparam int RD_LSB  = 21;
  localparam int RS1_LSB = 16;
  localparam int RS2_LSB = 11;
  localparam int IMM_W   = 16;

  localparam logic [5:0] OP_NOP  = 6'd0;
  localparam logic [5:0] OP_ADD  = 6'd1;
  localparam logic [5:0] OP_SUB  = 6'd2;
  localparam logic [5:0] OP_AND  = 6'd3;
  localparam logic [5:0] OP_OR   = 6'd4;
  localparam logic [5:0] OP_ADDI = 6'd5;
  localparam logic [5:0] OP_BEQ  = 6'd6;
  localparam logic [5:0] OP_BNE  = 6'd7;
  localparam logic [5:0] OP_LW   = 6'd8;
  localparam logic [5:0] OP_SW   = 6'd9;

  typedef struct packed {
    logic              valid;
    logic [5:0]        op;
    logic [REG_AW-1:0] rd;
    logic [XLEN-1:0]   rs1_data;
    logic [XLEN-1:0]   rs2_data;
    logic [XLEN-1:0]   imm;
    logic              we;
    logic              branch;
  } idex_t;

  function automatic logic op_writes_rd(input logic [5:0] op);
    return ((op >= OP_ADD) && (op <= OP_ADDI)) || (op == OP_LW);
  endfunction
endpackage

// File: rtl/triumph_regfile.sv
// 2-read / 1-write register file, r0 hardwired to zero, write-first bypass on reads.
module triumph_regfile
  import triumph_pkg::*;
(
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              we_i,
  input  logic [REG_AW-1:0] waddr_i,
  input  logic [XLEN-1:0]   wdata_i,
  input  logic [REG_AW-1:0] raddr_a_i,
  input  logic [REG_AW-1:0] raddr_b_i,
  output logic [XLEN-1:0]   rdata_a_o,
  output logic [XLEN-1:0]   rdata_b_o
);
  logic [XLEN-1:0] mem_q [NREGS];

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      for (int i = 0; i < NREGS; i++) mem_q[i] <= '0;
    end else if (we_i && (waddr_i != '0)) begin
      mem_q[waddr_i] <= wdata_i;
    end
  end

  // A write landing this cycle is visible to the reader in the same cycle.
  always_comb begin
    rdata_a_o = '0;
    rdata_b_o = '0;
    if (raddr_a_i != '0)
      rdata_a_o = (we_i && (waddr_i == raddr_a_i)) ? wdata_i : mem_q[raddr_a_i];
    if (raddr_b_i != '0)
      rdata_b_o = (we_i && (waddr_i == raddr_b_i)) ? wdata_i : mem_q[raddr_b_i];
  end
endmodule

// File: rtl/triumph_id_stage.sv
// Decode stage: field extraction, register read, load-use hazard detection and the ID/EX register.
module triumph_id_stage
  import triumph_pkg::*;
(
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              instr_valid_i,
  input  logic [XLEN-1:0]   instr_data_i,
  input  logic              stall_i,
  input  logic              flush_i,
  input  logic              wb_we_i,
  input  logic [REG_AW-1:0] wb_addr_i,
  input  logic [XLEN-1:0]   wb_data_i,
  output logic              ex_valid_o,
  output logic [5:0]        ex_op_o,
  output logic [REG_AW-1:0] ex_rd_o,
  output logic [XLEN-1:0]   ex_rs1_data_o,
  output logic [XLEN-1:0]   ex_rs2_data_o,
  output logic [XLEN-1:0]   ex_imm_o,
  output logic              ex_we_o,
  output logic              ex_branch_o,
  output logic [XLEN-1:0]   opPC_data_o,
  output logic              hazard_o,
  output logic              illegal_o
);
  logic [5:0]        op;
  logic [REG_AW-1:0] rd, rs1, rs2;
  logic [XLEN-1:0]   rs1_data, rs2_data;
  logic              legal;
  idex_t             dec, idex_d, idex_q;
  logic              illegal_d, illegal_q;

  assign op  = instr_data_i[OP_LSB +: 6];
  assign rd  = instr_data_i[RD_LSB +: REG_AW];
  assign rs1 = instr_data_i[RS1_LSB +: REG_AW];
  assign rs2 = instr_data_i[RS2_LSB +: REG_AW];
  assign legal = (op <= OP_SW);

  triumph_regfile u_regfile (
    .clk_i     (clk_i),
    .rst_i     (rst_i),
    .we_i      (wb_we_i),
    .waddr_i   (wb_addr_i),
    .wdata_i   (wb_data_i),
    .raddr_a_i (rs1),
    .raddr_b_i (rs2),
    .rdata_a_o (rs1_data),
    .rdata_b_o (rs2_data)
  );

  // Illegal opcodes travel down the pipe as a NOP.
  always_comb begin
    dec          = '0;
    dec.valid    = 1'b1;
    dec.op       = legal ? op : OP_NOP;
    dec.rd       = legal ? rd : '0;
    dec.rs1_data = rs1_data;
    dec.rs2_data = rs2_data;
    dec.imm      = {{(XLEN-IMM_W){instr_data_i[IMM_W-1]}}, instr_data_i[IMM_W-1:0]};
    dec.we       = legal && op_writes_rd(op) && (rd != '0);
    dec.branch   = (op == OP_BEQ) || (op == OP_BNE);
  end

  assign hazard_o = idex_q.valid && (idex_q.op == OP_LW) && (idex_q.rd != '0) && instr_valid_i &&
                    ((idex_q.rd == rs1) || (idex_q.rd == rs2));

  always_comb begin
    idex_d    = idex_q;
    illegal_d = 1'b0;
    if (flush_i) begin
      idex_d = '0;
    end else if (stall_i) begin
      idex_d = idex_q;
    end else if (hazard_o || !instr_valid_i) begin
      idex_d = '0;
    end else begin
      idex_d    = dec;
      illegal_d = !legal;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      idex_q    <= '0;
      illegal_q <= 1'b0;
    end else begin
      idex_q    <= idex_d;
      illegal_q <= illegal_d;
    end
  end

  assign ex_valid_o    = idex_q.valid;
  assign ex_op_o       = idex_q.op;
  assign ex_rd_o       = idex_q.rd;
  assign ex_rs1_data_o = idex_q.rs1_data;
  assign ex_rs2_data_o = idex_q.rs2_data;
  assign ex_imm_o      = idex_q.imm;
  assign ex_we_o       = idex_q.we;
  assign ex_branch_o   = idex_q.branch;
  assign opPC_data_o   = idex_q.branch ? idex_q.imm : '0;
  assign illegal_o     = illegal_q;
endmodule

// File: tb/tb_triumph_id_stage.sv
// Self-checking bench for triumph_id_stage: directed scenarios plus a randomized run against a reference model.
module tb_triumph_id_stage;
  logic        clk_i = 1'b0;
  logic        rst_i = 1'b1;
  logic        instr_valid_i = 1'b0;
  logic [31:0] instr_data_i = '0;
  logic        stall_i = 1'b0, flush_i = 1'b0, wb_we_i = 1'b0;
  logic [4:0]  wb_addr_i = '0;
  logic [31:0] wb_data_i = '0;
  logic        ex_valid_o, ex_we_o, ex_branch_o, hazard_o, illegal_o;
  logic [5:0]  ex_op_o;
  logic [4:0]  ex_rd_o;
  logic [31:0] ex_rs1_data_o, ex_rs2_data_o, ex_imm_o, opPC_data_o;

  int errors = 0;
  int checks = 0;

  triumph_id_stage dut (
    .clk_i(clk_i), .rst_i(rst_i), .instr_valid_i(instr_valid_i), .instr_data_i(instr_data_i),
    .stall_i(stall_i), .flush_i(flush_i), .wb_we_i(wb_we_i), .wb_addr_i(wb_addr_i),
    .wb_data_i(wb_data_i), .ex_valid_o(ex_valid_o), .ex_op_o(ex_op_o), .ex_rd_o(ex_rd_o),
    .ex_rs1_data_o(ex_rs1_data_o), .ex_rs2_data_o(ex_rs2_data_o), .ex_imm_o(ex_imm_o),
    .ex_we_o(ex_we_o), .ex_branch_o(ex_branch_o), .opPC_data_o(opPC_data_o),
    .hazard_o(hazard_o), .illegal_o(illegal_o)
  );

  always #5 clk_i = ~clk_i;

  function automatic logic [31:0] enc(input int op, input int rd, input int rs1, input int low16);
    logic [31:0] o, r, s, l;
    o = op; r = rd; s = rs1; l = low16;
    return {o[5:0], r[4:0], s[4:0], l[15:0]};
  endfunction

  task automatic idle_inputs();
    instr_valid_i = 1'b0; instr_data_i = '0; stall_i = 1'b0; flush_i = 1'b0;
    wb_we_i = 1'b0; wb_addr_i = '0; wb_data_i = '0;
  endtask

  task automatic do_reset();
    @(negedge clk_i);
    idle_inputs();
    rst_i = 1'b1;
    @(negedge clk_i);
    rst_i = 1'b0;
  endtask

  task automatic test_reset();
    idle_inputs();
    #1;
    checks++;
    if ({ex_valid_o, ex_op_o, ex_rd_o, ex_rs1_data_o, ex_rs2_data_o, ex_imm_o, ex_we_o,
         ex_branch_o, opPC_data_o, hazard_o, illegal_o} !== '0) begin
      errors++; $display("FAIL reset_outputs: valid=%0b op=%0d rd=%0d imm=%h we=%0b, need all zero",
                         ex_valid_o, ex_op_o, ex_rd_o, ex_imm_o, ex_we_o);
    end
    @(negedge clk_i); rst_i = 1'b0;
    instr_valid_i = 1'b1; instr_data_i = 32'h1420_0005;
    @(posedge clk_i); #1;
    checks++;
    if ({ex_valid_o, ex_op_o, ex_rd_o, ex_imm_o, ex_we_o} !== {1'b1, 6'd5, 5'd1, 32'd5, 1'b1}) begin
      errors++; $display("FAIL addi_load: valid=%0b op=%0d rd=%0d imm=%h we=%0b, need 1/5/1/5/1",
                         ex_valid_o, ex_op_o, ex_rd_o, ex_imm_o, ex_we_o);
    end
    // Asynchronous reset mid-cycle clears outputs without waiting for an edge.
    #2 rst_i = 1'b1;
    #1;
    checks++;
    if ({ex_valid_o, ex_we_o, ex_op_o} !== '0) begin
      errors++; $display("FAIL async_reset: valid=%0b we=%0b op=%0d, need 0", ex_valid_o, ex_we_o, ex_op_o);
    end
    @(negedge clk_i); rst_i = 1'b0;
    idle_inputs();
  endtask

  task automatic test_bypass();
    @(negedge clk_i);
    instr_valid_i = 1'b1; instr_data_i = enc(1, 3, 2, 2 << 11);
    wb_we_i = 1'b1; wb_addr_i = 5'd2; wb_data_i = 32'hDEAD_BEEF;
    @(posedge clk_i); #1;
    checks++;
    if (ex_rs1_data_o !== 32'hDEAD_BEEF || ex_rs2_data_o !== 32'hDEAD_BEEF) begin
      errors++; $display("FAIL wb_bypass: rs1=%h rs2=%h, need deadbeef", ex_rs1_data_o, ex_rs2_data_o);
    end
    @(negedge clk_i);
    wb_we_i = 1'b0; instr_data_i = enc(1, 3, 0, 2 << 11);
    @(posedge clk_i); #1;
    checks++;
    if (ex_rs2_data_o !== 32'hDEAD_BEEF || ex_rs1_data_o !== 32'h0) begin
      errors++; $display("FAIL wb_commit: rs1=%h rs2=%h, need 0/deadbeef", ex_rs1_data_o, ex_rs2_data_o);
    end
  endtask

  task automatic test_branch_flush();
    @(negedge clk_i);
    instr_valid_i = 1'b1; instr_data_i = enc(6, 0, 1, 16'hFFFC);
    @(posedge clk_i); #1;
    checks++;
    if (ex_branch_o !== 1'b1 || opPC_data_o !== 32'hFFFF_FFFC || ex_we_o !== 1'b0) begin
      errors++; $display("FAIL beq_offset: branch=%0b opPC=%h we=%0b, need 1/fffffffc/0",
                         ex_branch_o, opPC_data_o, ex_we_o);
    end
    @(negedge clk_i);
    flush_i = 1'b1; instr_data_i = enc(1, 4, 1, 0);
    @(posedge clk_i); #1;
    checks++;
    if (ex_valid_o !== 1'b0 || opPC_data_o !== 32'h0 || ex_branch_o !== 1'b0) begin
      errors++; $display("FAIL flush: valid=%0b opPC=%h branch=%0b, need 0", ex_valid_o, opPC_data_o, ex_branch_o);
    end
    @(negedge clk_i); flush_i = 1'b0;
  endtask

  task automatic test_hazard();
    @(negedge clk_i);
    instr_valid_i = 1'b1; instr_data_i = enc(8, 4, 0, 0);
    @(posedge clk_i); #1;
    checks++;
    if (ex_valid_o !== 1'b1 || ex_op_o !== 6'd8 || ex_we_o !== 1'b1) begin
      errors++; $display("FAIL lw_load: valid=%0b op=%0d we=%0b, need 1/8/1", ex_valid_o, ex_op_o, ex_we_o);
    end
    @(negedge clk_i);
    instr_data_i = enc(1, 5, 4, 0);
    #1;
    checks++;
    if (hazard_o !== 1'b1) begin
      errors++; $display("FAIL hazard_flag: hazard=%0b, need 1", hazard_o);
    end
    @(posedge clk_i); #1;
    checks++;
    if (ex_valid_o !== 1'b0 || ex_we_o !== 1'b0 || hazard_o !== 1'b0) begin
      errors++; $display("FAIL hazard_bubble: valid=%0b we=%0b hazard=%0b, need 0", ex_valid_o, ex_we_o, hazard_o);
    end
    @(posedge clk_i); #1;
    checks++;
    if (ex_valid_o !== 1'b1 || ex_op_o !== 6'd1 || ex_rd_o !== 5'd5) begin
      errors++; $display("FAIL hazard_retry: valid=%0b op=%0d rd=%0d, need 1/1/5", ex_valid_o, ex_op_o, ex_rd_o);
    end
  endtask

  task automatic test_stall();
    @(negedge clk_i);
    instr_valid_i = 1'b1; instr_data_i = enc(5, 6, 0, 16'h0077);
    @(posedge clk_i);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk_i);
      stall_i = 1'b1; instr_data_i = enc(1 + i, 7 + i, 1, 0);
      @(posedge clk_i); #1;
      checks++;
      if ({ex_valid_o, ex_op_o, ex_rd_o, ex_imm_o, ex_we_o} !== {1'b1, 6'd5, 5'd6, 32'h77, 1'b1}) begin
        errors++; $display("FAIL stall_hold%0d: valid=%0b op=%0d rd=%0d imm=%h, need 1/5/6/77",
                           i, ex_valid_o, ex_op_o, ex_rd_o, ex_imm_o);
      end
    end
    @(negedge clk_i); flush_i = 1'b1;
    @(posedge clk_i); #1;
    checks++;
    if (ex_valid_o !== 1'b0 || ex_we_o !== 1'b0) begin
      errors++; $display("FAIL stall_flush: valid=%0b we=%0b, need 0", ex_valid_o, ex_we_o);
    end
    @(negedge clk_i); idle_inputs();
  endtask

  task automatic test_illegal_r0();
    @(negedge clk_i);
    instr_valid_i = 1'b1; instr_data_i = enc(63, 9, 1, 0);
    @(posedge clk_i); #1;
    checks++;
    if (illegal_o !== 1'b1 || ex_we_o !== 1'b0 || ex_valid_o !== 1'b1 || ex_op_o !== 6'd0) begin
      errors++; $display("FAIL illegal_load: ill=%0b we=%0b valid=%0b op=%0d, need 1/0/1/0",
                         illegal_o, ex_we_o, ex_valid_o, ex_op_o);
    end
    @(negedge clk_i);
    instr_data_i = enc(0, 0, 0, 0);
    wb_we_i = 1'b1; wb_addr_i = 5'd0; wb_data_i = 32'h1234_5678;
    @(posedge clk_i); #1;
    checks++;
    if (illegal_o !== 1'b0) begin
      errors++; $display("FAIL illegal_pulse: ill=%0b, need 0", illegal_o);
    end
    @(negedge clk_i);
    wb_we_i = 1'b1; instr_data_i = enc(1, 7, 0, 0);
    @(posedge clk_i); #1;
    checks++;
    if (ex_rs1_data_o !== 32'h0 || ex_rs2_data_o !== 32'h0) begin
      errors++; $display("FAIL r0_bypass: rs1=%h rs2=%h, need 0", ex_rs1_data_o, ex_rs2_data_o);
    end
    @(negedge clk_i);
    wb_we_i = 1'b0;
    @(posedge clk_i); #1;
    checks++;
    if (ex_rs1_data_o !== 32'h0) begin
      errors++; $display("FAIL r0_readback: rs1=%h, need 0", ex_rs1_data_o);
    end
    @(negedge clk_i); idle_inputs();
  endtask

  // Reference model state: what EX should be holding and the architectural registers.
  logic [31:0] m_regs [32];
  logic        m_valid, m_we, m_br, m_ill;
  int          m_op, m_rd;
  logic [31:0] m_a, m_b, m_imm;

  function automatic logic [31:0] m_read(input int r, input logic we, input int wa, input logic [31:0] wd);
    if (r == 0) return 32'h0;
    if (we && wa == r) return wd;
    return m_regs[r];
  endfunction

  task automatic test_random();
    int op, rd, rs1, rs2, low;
    logic exp_haz, legal;
    logic [31:0] exp_pc;
    do_reset();
    for (int i = 0; i < 32; i++) m_regs[i] = '0;
    m_valid = 0; m_we = 0; m_br = 0; m_ill = 0; m_op = 0; m_rd = 0; m_a = 0; m_b = 0; m_imm = 0;
    for (int cyc = 0; cyc < 400; cyc++) begin
      @(negedge clk_i);
      op  = $urandom_range(0, 13);
      if (op >= 12) op = 8;
      else if (op >= 10) op = $urandom_range(10, 63);
      rd  = $urandom_range(0, 7); rs1 = $urandom_range(0, 7); rs2 = $urandom_range(0, 7);
      low = ($urandom_range(0, 65535) & 16'h07FF) | (rs2 << 11);
      instr_data_i  = enc(op, rd, rs1, low);
      instr_valid_i = ($urandom_range(0, 99) < 85);
      stall_i       = ($urandom_range(0, 99) < 20);
      flush_i       = ($urandom_range(0, 99) < 10);
      wb_we_i       = $urandom_range(0, 1);
      wb_addr_i     = 5'($urandom_range(0, 7));
      wb_data_i     = $urandom;
      #1;
      exp_haz = m_valid && m_op == 8 && m_rd != 0 && instr_valid_i && (m_rd == rs1 || m_rd == rs2);
      exp_pc  = m_br ? m_imm : 32'h0;
      checks++;
      if (hazard_o !== exp_haz) begin
        errors++; $display("FAIL rnd_hazard c%0d: got %0b need %0b", cyc, hazard_o, exp_haz);
      end
      checks++;
      if ({ex_valid_o, ex_we_o, ex_branch_o, illegal_o, opPC_data_o} !== {m_valid, m_we, m_br, m_ill, exp_pc}) begin
        errors++; $display("FAIL rnd_ctrl c%0d: valid/we/br/ill/pc got %0b%0b%0b%0b/%h need %0b%0b%0b%0b/%h", cyc,
                           ex_valid_o, ex_we_o, ex_branch_o, illegal_o, opPC_data_o, m_valid, m_we, m_br, m_ill, exp_pc);
      end
      if (m_valid) begin
        checks++;
        if (ex_op_o !== 6'(m_op) || ex_rs1_data_o !== m_a || ex_rs2_data_o !== m_b || ex_imm_o !== m_imm ||
            (m_op != 0 && ex_rd_o !== 5'(m_rd))) begin
          errors++; $display("FAIL rnd_data c%0d: op=%0d rd=%0d a=%h b=%h imm=%h need %0d/%0d/%h/%h/%h", cyc,
                             ex_op_o, ex_rd_o, ex_rs1_data_o, ex_rs2_data_o, ex_imm_o, m_op, m_rd, m_a, m_b, m_imm);
        end
      end
      // Advance the model by one clock edge.
      if (flush_i) begin
        m_valid = 0; m_we = 0; m_br = 0; m_ill = 0;
      end else if (stall_i) begin
        m_ill = 0;
      end else if (exp_haz || !instr_valid_i) begin
        m_valid = 0; m_we = 0; m_br = 0; m_ill = 0;
      end else begin
        legal   = (op <= 9);
        m_valid = 1;
        m_ill   = !legal;
        m_op    = legal ? op : 0;
        m_rd    = rd;
        m_a     = m_read(rs1, wb_we_i, int'(wb_addr_i), wb_data_i);
        m_b     = m_read(rs2, wb_we_i, int'(wb_addr_i), wb_data_i);
        m_imm   = 32'(int'($signed(16'(low))));
        m_we    = legal && ((op >= 1 && op <= 5) || op == 8) && rd != 0;
        m_br    = (op == 6 || op == 7);
      end
      if (wb_we_i && wb_addr_i != 0) m_regs[wb_addr_i] = wb_data_i;
      @(posedge clk_i);
    end
    @(negedge clk_i); idle_inputs();
  endtask

  initial begin
    test_reset();
    test_bypass();
    test_branch_flush();
    test_hazard();
    test_stall();
    test_illegal_r0();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
